// File: rtl/dcp_link_arbiter.sv
// rtl/dcp_link_arbiter.sv - shares one print (TX) and one scan (RX) path among N command handlers
// Build option: DCP_ARB_FIXED_PRIO_EN selects lowest-index-wins priority instead of round-robin.

module dcp_link_arbiter_chan #(
  parameter int N  = 4,
  parameter int DW = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req_in,
  input  logic [DW*N-1:0] payload_in,
  input  logic            ack,
  output logic            req,
  output logic [DW-1:0]   payload,
  output logic [N-1:0]    ack_out,
  output logic [2:0]      gnt
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          req_n;
  logic [DW-1:0] payload_n;
  logic [DW-1:0] pick_payload;
  logic [N-1:0]  ack_out_n;
  logic [2:0]    gnt_n;
  logic [2:0]    pick;
  logic          found;
  logic          grant;
  logic          cur_req;

`ifdef DCP_ARB_FIXED_PRIO_EN
  always_comb begin
    logic [N-1:0] sh;
    found = |req_in;
    pick  = '0;
    sh    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sh = req_in >> k;
      if (sh[0]) pick = 3'(k);
    end
  end
`else
  logic [2:0] ptr;

  // Walk from the farthest candidate to the nearest so the first requester after ptr wins.
  always_comb begin
    logic [N-1:0] sh;
    int           idx;
    found = |req_in;
    pick  = '0;
    sh    = '0;
    idx   = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      sh  = req_in >> idx;
      if (sh[0]) pick = 3'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= 3'(N - 1);
    end else if (grant) begin
      ptr <= pick;
    end
  end
`endif

  always_comb begin
    logic [N-1:0] sel;
    sel          = req_in >> gnt;
    cur_req      = sel[0];
    pick_payload = DW'(payload_in >> (DW * int'(pick)));
  end

  always_comb begin
    state_n   = state;
    req_n     = req;
    payload_n = payload;
    ack_out_n = '0;
    gnt_n     = gnt;
    grant     = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant     = 1'b1;
          gnt_n     = pick;
          payload_n = pick_payload;
          req_n     = 1'b1;
          state_n   = S_WAIT;
        end
      end
      S_WAIT: begin
        // The transfer cannot be cancelled: the grantee is acked even if it has dropped req.
        if (ack) begin
          ack_out_n = N'(1) << gnt;
          req_n     = 1'b0;
          state_n   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!cur_req) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      req     <= 1'b0;
      payload <= '0;
      ack_out <= '0;
      gnt     <= '0;
    end else begin
      state   <= state_n;
      req     <= req_n;
      payload <= payload_n;
      ack_out <= ack_out_n;
      gnt     <= gnt_n;
    end
  end
endmodule

module dcp_link_arbiter #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req_tx_in,
  input  logic [N-1:0]    type_tx_in,
  input  logic [32*N-1:0] dout_in,
  output logic [N-1:0]    ack_tx_out,
  output logic            req_tx,
  output logic            type_tx,
  output logic [31:0]     dout_tx,
  input  logic            ack_tx,
  input  logic [N-1:0]    req_rx_in,
  input  logic [N-1:0]    type_rx_in,
  output logic [N-1:0]    ack_rx_out,
  output logic            req_rx,
  output logic            type_rx,
  input  logic            ack_rx,
  output logic [2:0]      gnt_tx,
  output logic [2:0]      gnt_rx
);
  // TX payload per handler is {type, data}; RX carries only the type.
  logic [33*N-1:0] tx_payload_in;
  logic [32:0]     tx_payload;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign tx_payload_in[33*i +: 33] = {type_tx_in[i], dout_in[32*i +: 32]};
  end

  assign {type_tx, dout_tx} = tx_payload;

  dcp_link_arbiter_chan #(.N(N), .DW(33)) u_tx (
    .clk        (clk),
    .rstn       (rstn),
    .req_in     (req_tx_in),
    .payload_in (tx_payload_in),
    .ack        (ack_tx),
    .req        (req_tx),
    .payload    (tx_payload),
    .ack_out    (ack_tx_out),
    .gnt        (gnt_tx)
  );

  dcp_link_arbiter_chan #(.N(N), .DW(1)) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .req_in     (req_rx_in),
    .payload_in (type_rx_in),
    .ack        (ack_rx),
    .req        (req_rx),
    .payload    (type_rx),
    .ack_out    (ack_rx_out),
    .gnt        (gnt_rx)
  );
endmodule
